csl_ctrl_gen: RTL and testbench

//   Parametrised console/CPU control interface. Holds NFLAGS console-settable run-control flags
//   (bit0 RUN, bit1 CONT, bit2 EXEC, higher bits free). Adds masked console writes with a one-deep

---
 rtl/csl_pkg.sv | 14 +
 rtl/csl_wrbuf.sv | 41 ++++
 rtl/csl_ctrl_gen.sv | 160 ++++++++++++++++
 tb/tb_csl_ctrl_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/csl_pkg.sv
// Shared constants for the console control slice: flag bit positions and
// halt-request FSM state encodings.
package csl_pkg;

  localparam int unsigned CSL_RUN  = 0;
  localparam int unsigned CSL_CONT = 1;
  localparam int unsigned CSL_EXEC = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hreq_state_t;

endpackage

// File: rtl/csl_wrbuf.sv
// One-deep console write buffer. Captures mask/data on any clk; drains on
// the first clken cycle it is full. A request arriving in the drain cycle
// refills the buffer, so busy stays high.
module csl_wrbuf #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             wrReq,
  input  logic [WIDTH-1:0] wrMask,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             drain,
  output logic [WIDTH-1:0] bufMask,
  output logic [WIDTH-1:0] bufData
);

  logic full;
  logic capture;

  assign drain   = full & clken;
  assign capture = wrReq & (~full | drain);
  assign busy    = full;

  // Buffer occupancy and contents; requests while full and not draining are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      bufMask <= '0;
      bufData <= '0;
    end else if (capture) begin
      full    <= 1'b1;
      bufMask <= wrMask;
      bufData <= wrData;
    end else if (drain) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/csl_ctrl_gen.sv
// Console/CPU control interface: console-settable run-control flags fed
// through a one-deep write buffer, CPU halt latch, and a console
// halt-request FSM. Optional halt-request timeout selected by the
// CSL_HREQ_TMO_EN macro.
module csl_ctrl_gen
  import csl_pkg::*;
#(
  parameter int unsigned           NFLAGS    = 3,
  parameter int unsigned           TMO_WIDTH = 16,
  parameter logic [TMO_WIDTH-1:0]  TMO_LIMIT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              ucSET_HALT,
  input  logic              ucCLR_HALT,
  input  logic [NFLAGS-1:0] ucCLR,
  input  logic              cslSET,
  input  logic [NFLAGS-1:0] cslMASK,
  input  logic [NFLAGS-1:0] cslDATA,
  output logic              cslBUSY,
  input  logic              cslHREQ,
  output logic [NFLAGS-1:0] cpuFLAGS,
  output logic              cpuHALT,
  output logic              hreqPEND,
  output logic              hreqTMO
);

  hreq_state_t       state, nextState;
  logic [NFLAGS-1:0] flags;
  logic [NFLAGS-1:0] bufMask, bufData;
  logic              drain;
  logic              haltReg;
  logic              hreqLatch;
  logic              hreqSeen;
  logic              inWait;
  logic              tmoHit;

  csl_wrbuf #(.WIDTH(NFLAGS)) uWrbuf (
    .clk     (clk),
    .rst     (rst),
    .clken   (clken),
    .wrReq   (cslSET),
    .wrMask  (cslMASK),
    .wrData  (cslDATA),
    .busy    (cslBUSY),
    .drain   (drain),
    .bufMask (bufMask),
    .bufData (bufData)
  );

  assign hreqSeen = cslHREQ | hreqLatch;
  assign cpuHALT  = haltReg;

  // Hold a console halt request that arrives while clken is low until the next clken cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hreqLatch <= 1'b0;
    else if (clken)
      hreqLatch <= 1'b0;
    else if (cslHREQ && state == ST_IDLE)
      hreqLatch <= 1'b1;
  end

`ifdef CSL_HREQ_TMO_EN
  logic [TMO_WIDTH-1:0] tmoCnt;
  logic                 tmoReg;

  assign tmoHit  = (tmoCnt == TMO_LIMIT);
  assign hreqTMO = tmoReg;

  // Timeout counter: cleared while idle, saturating count of clken cycles in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmoCnt <= '0;
    else if (clken) begin
      if (state == ST_IDLE)
        tmoCnt <= '0;
      else if (!tmoHit)
        tmoCnt <= tmoCnt + 1'b1;
    end
  end

  // Sticky timeout flag: set on timeout exit, cleared when a new request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmoReg <= 1'b0;
    else if (clken) begin
      if (state == ST_IDLE && hreqSeen)
        tmoReg <= 1'b0;
      else if (state == ST_WAIT && !haltReg && tmoHit)
        tmoReg <= 1'b1;
    end
  end
`else
  logic unusedTmo;

  assign tmoHit    = 1'b0;
  assign hreqTMO   = 1'b0;
  assign unusedTmo = ^TMO_LIMIT ^ (TMO_WIDTH == 0);
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= nextState;
  end

  // FSM next-state logic; a request while already halted is absorbed in IDLE.
  always_comb begin
    nextState = state;
    if (clken) begin
      case (state)
        ST_IDLE: if (hreqSeen && !haltReg) nextState = ST_WAIT;
        ST_WAIT: if (haltReg || tmoHit)    nextState = ST_IDLE;
        default: nextState = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; RUN reads 0 for the whole WAIT period.
  always_comb begin
    inWait   = (state == ST_WAIT);
    hreqPEND = inWait;
    cpuFLAGS = flags;
    if (inWait)
      cpuFLAGS[CSL_RUN] = 1'b0;
  end

  // CPU halt latch; SET beats CLR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      haltReg <= 1'b0;
    else if (clken) begin
      if (ucSET_HALT)
        haltReg <= 1'b1;
      else if (ucCLR_HALT)
        haltReg <= 1'b0;
    end
  end

  // Flag register: microcode clear beats the WAIT RUN force, which beats the console write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags <= '0;
    else if (clken) begin
      for (int unsigned i = 0; i < NFLAGS; i++) begin
        if (ucCLR[i])
          flags[i] <= 1'b0;
        else if (i == CSL_RUN && inWait)
          flags[i] <= 1'b0;
        else if (drain && bufMask[i])
          flags[i] <= bufData[i];
      end
    end
  end

endmodule

// File: tb/tb_csl_ctrl_gen.sv
// Directed self-checking bench for csl_ctrl_gen (NFLAGS=3, TMO_LIMIT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_csl_ctrl_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       clken;
  logic       ucSET_HALT, ucCLR_HALT;
  logic [2:0] ucCLR;
  logic       cslSET;
  logic [2:0] cslMASK, cslDATA;
  logic       cslBUSY;
  logic       cslHREQ;
  logic [2:0] cpuFLAGS;
  logic       cpuHALT, hreqPEND, hreqTMO;

  int unsigned passCnt  = 0;
  int unsigned totalCnt = 0;

  csl_ctrl_gen #(
    .NFLAGS    (3),
    .TMO_WIDTH (16),
    .TMO_LIMIT (16'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .ucSET_HALT (ucSET_HALT),
    .ucCLR_HALT (ucCLR_HALT),
    .ucCLR      (ucCLR),
    .cslSET     (cslSET),
    .cslMASK    (cslMASK),
    .cslDATA    (cslDATA),
    .cslBUSY    (cslBUSY),
    .cslHREQ    (cslHREQ),
    .cpuFLAGS   (cpuFLAGS),
    .cpuHALT    (cpuHALT),
    .hreqPEND   (hreqPEND),
    .hreqTMO    (hreqTMO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1;
    ucSET_HALT = 1'b0; ucCLR_HALT = 1'b0; ucCLR = 3'b000;
    cslSET = 1'b0; cslMASK = 3'b000; cslDATA = 3'b000; cslHREQ = 1'b0;
    cyc(2);
    chk("rst_flags", {29'd0, cpuFLAGS}, 32'h0);
    chk("rst_busy",  {31'd0, cslBUSY},  32'h0);
    chk("rst_halt",  {31'd0, cpuHALT},  32'h0);
    chk("rst_pend",  {31'd0, hreqPEND}, 32'h0);
    chk("rst_tmo",   {31'd0, hreqTMO},  32'h0);
    rst = 1'b0;
    cyc(1);

    // Basic write: busy one cycle, then flags updated
    cslSET = 1'b1; cslMASK = 3'b101; cslDATA = 3'b101;
    cyc(1);
    cslSET = 1'b0;
    chk("wr1_busy",  {31'd0, cslBUSY},  32'h1);
    chk("wr1_hold",  {29'd0, cpuFLAGS}, 32'h0);
    cyc(1);
    chk("wr1_flags", {29'd0, cpuFLAGS}, 32'h5);
    chk("wr1_idle",  {31'd0, cslBUSY},  32'h0);

    // Capture with clken low; second write while busy is dropped
    clken = 1'b0;
    cslSET = 1'b1; cslMASK = 3'b010; cslDATA = 3'b010;
    cyc(1);
    chk("wr2_busy", {31'd0, cslBUSY}, 32'h1);
    cslMASK = 3'b001; cslDATA = 3'b000;
    cyc(1);
    cslSET = 1'b0;
    cyc(3);
    chk("wr2_frozen", {29'd0, cpuFLAGS}, 32'h5);
    clken = 1'b1;
    cyc(1);
    chk("wr2_cont", {29'd0, cpuFLAGS}, 32'h7);
    chk("wr2_free", {31'd0, cslBUSY},  32'h0);
    cyc(1);
    chk("wr2_dropped", {29'd0, cpuFLAGS}, 32'h7);

    // Microcode clear beats buffered console set of RUN
    cslSET = 1'b1; cslMASK = 3'b001; cslDATA = 3'b001;
    cyc(1);
    cslSET = 1'b0; ucCLR = 3'b001;
    cyc(1);
    ucCLR = 3'b000;
    chk("clr_wins", {29'd0, cpuFLAGS}, 32'h6);

    // Write arriving in the drain cycle is captured; busy stays high
    cslSET = 1'b1; cslMASK = 3'b001; cslDATA = 3'b001;
    cyc(1);
    cslMASK = 3'b010; cslDATA = 3'b000;
    cyc(1);
    cslSET = 1'b0;
    chk("refill_busy",  {31'd0, cslBUSY},  32'h1);
    chk("refill_first", {29'd0, cpuFLAGS}, 32'h7);
    cyc(1);
    chk("refill_second", {29'd0, cpuFLAGS}, 32'h5);

    // SET_HALT beats CLR_HALT
    ucSET_HALT = 1'b1; ucCLR_HALT = 1'b1;
    cyc(1);
    ucSET_HALT = 1'b0;
    chk("halt_set_wins", {31'd0, cpuHALT}, 32'h1);
    cyc(1);
    ucCLR_HALT = 1'b0;
    chk("halt_clr", {31'd0, cpuHALT}, 32'h0);

    // Halt request, satisfied by microcode halt before any timeout
    cslHREQ = 1'b1;
    cyc(1);
    cslHREQ = 1'b0;
    chk("hreq_pend",    {31'd0, hreqPEND}, 32'h1);
    chk("hreq_runmask", {29'd0, cpuFLAGS}, 32'h4);
    cyc(5);
    chk("hreq_still", {31'd0, hreqPEND}, 32'h1);
    ucSET_HALT = 1'b1;
    cyc(1);
    ucSET_HALT = 1'b0;
    cyc(1);
    chk("hreq_halted", {31'd0, cpuHALT},  32'h1);
    chk("hreq_done",   {31'd0, hreqPEND}, 32'h0);
    chk("hreq_notmo",  {31'd0, hreqTMO},  32'h0);
    chk("hreq_runclr", {29'd0, cpuFLAGS}, 32'h4);

    // Request while already halted is absorbed
    cslHREQ = 1'b1;
    cyc(1);
    cslHREQ = 1'b0;
    chk("hreq_absorbed", {31'd0, hreqPEND}, 32'h0);
    ucCLR_HALT = 1'b1;
    cyc(1);
    ucCLR_HALT = 1'b0;

    // Unanswered request: timeout after the 9th clken (TMO_LIMIT=8)
    cslHREQ = 1'b1;
    cyc(1);
    cslHREQ = 1'b0;
    cyc(8);
    chk("tmo_pend8", {31'd0, hreqPEND}, 32'h1);
    chk("tmo_none8", {31'd0, hreqTMO},  32'h0);
    cyc(1);
`ifdef CSL_HREQ_TMO_EN
    chk("tmo_exit", {31'd0, hreqPEND}, 32'h0);
    chk("tmo_set",  {31'd0, hreqTMO},  32'h1);
    clken = 1'b0;
    cslHREQ = 1'b1;
    cyc(1);
    cslHREQ = 1'b0;
    chk("tmo_latched_idle", {31'd0, hreqPEND}, 32'h0);
    chk("tmo_sticky",       {31'd0, hreqTMO},  32'h1);
    clken = 1'b1;
    cyc(1);
    chk("tmo_rereq_pend", {31'd0, hreqPEND}, 32'h1);
    chk("tmo_cleared",    {31'd0, hreqTMO},  32'h0);
`else
    chk("notmo_pend", {31'd0, hreqPEND}, 32'h1);
    chk("notmo_tmo",  {31'd0, hreqTMO},  32'h0);
    cyc(20);
    chk("notmo_pend_long", {31'd0, hreqPEND}, 32'h1);
`endif

    // Asynchronous reset mid-operation abandons buffer and FSM
    clken = 1'b0;
    cslSET = 1'b1; cslMASK = 3'b111; cslDATA = 3'b111;
    cyc(1);
    cslSET = 1'b0;
    chk("mid_busy", {31'd0, cslBUSY}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy",  {31'd0, cslBUSY},  32'h0);
    chk("mid_rst_pend",  {31'd0, hreqPEND}, 32'h0);
    chk("mid_rst_flags", {29'd0, cpuFLAGS}, 32'h0);
    cyc(1);
    rst = 1'b0; clken = 1'b1;
    cyc(2);
    chk("post_rst_flags", {29'd0, cpuFLAGS}, 32'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
